// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pipelined LEGv8 control unit.
// ctrl_t travels through the stage registers; id_info_t is consumed in ID only.
package ctrl_pkg;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;

    localparam logic [1:0] SRC_REG    = 2'b00;
    localparam logic [1:0] SRC_DADDR9 = 2'b01;
    localparam logic [1:0] SRC_IMM12  = 2'b10;
    localparam logic [1:0] SRC_MOV    = 2'b11;

    localparam logic [10:0] OP_ADDI  = 11'b1001000100?;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_B     = 11'b000101?????;
    localparam logic [10:0] OP_BCOND = 11'b01010100???;
    localparam logic [10:0] OP_CBZ   = 11'b10110100???;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_LDURB = 11'b00111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_STURB = 11'b00111000000;
    localparam logic [10:0] OP_MOVZ  = 11'b110100101??;
    localparam logic [10:0] OP_MOVK  = 11'b111100101??;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] alu_src;
        logic       set_flag;
        logic       is_movz;
        logic       is_mov;
        logic       mem_write;
        logic       mem_read;
        logic       mem_ze;
        logic [3:0] xfer_size;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic uncond;
        logic cbz;
        logic blt;
        logic use_rn;
        logic use_rb;
    } id_info_t;

    localparam ctrl_t    CTRL_BUBBLE = '0;
    localparam id_info_t ID_NONE     = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational LEGv8 decoder: opcode field to control bundle and register indices.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr,
    output ctrl_t             ctrl,
    output id_info_t          info,
    output logic [REG_AW-1:0] rn,
    output logic [REG_AW-1:0] rb,
    output logic [REG_AW-1:0] rd
);

    logic       rb_hi;
    logic       unused_bits;
    logic [10:0] op;

    assign op          = instr[31:21];
    assign rn          = instr[5 +: REG_AW];
    assign rd          = instr[0 +: REG_AW];
    assign rb          = rb_hi ? instr[16 +: REG_AW] : instr[0 +: REG_AW];
    assign unused_bits = ^instr;

    always_comb begin
        ctrl  = CTRL_BUBBLE;
        info  = ID_NONE;
        rb_hi = 1'b0;
        casez (op)
            OP_ADDI: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = SRC_IMM12;
                ctrl.reg_write = 1'b1;
                info.use_rn    = 1'b1;
            end
            OP_ADDS, OP_SUBS: begin
                ctrl.alu_op    = (op == OP_SUBS) ? ALU_SUB : ALU_ADD;
                ctrl.alu_src   = SRC_REG;
                ctrl.set_flag  = 1'b1;
                ctrl.reg_write = 1'b1;
                info.use_rn    = 1'b1;
                info.use_rb    = 1'b1;
                rb_hi          = 1'b1;
            end
            OP_B:     info.uncond = 1'b1;
            OP_BCOND: info.blt    = 1'b1;
            OP_CBZ: begin
                info.cbz    = 1'b1;
                info.use_rb = 1'b1;
            end
            OP_LDUR, OP_LDURB: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = SRC_DADDR9;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_ze     = (op == OP_LDURB);
                ctrl.xfer_size  = (op == OP_LDURB) ? 4'b0001 : 4'b1000;
                info.use_rn     = 1'b1;
            end
            OP_STUR, OP_STURB: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = SRC_DADDR9;
                ctrl.mem_write = 1'b1;
                ctrl.xfer_size = (op == OP_STURB) ? 4'b0001 : 4'b1000;
                info.use_rn    = 1'b1;
                info.use_rb    = 1'b1;
            end
            OP_MOVZ, OP_MOVK: begin
                ctrl.alu_op    = ALU_PASS;
                ctrl.alu_src   = SRC_MOV;
                ctrl.is_mov    = 1'b1;
                ctrl.is_movz   = (op[10:2] == OP_MOVZ[10:2]);
                ctrl.reg_write = 1'b1;
                info.use_rb    = 1'b1;
            end
            default: ;
        endcase
        // Writes to XZR are discarded here so they can never look like a producer downstream.
        ctrl.reg_write = ctrl.reg_write & (rd != '1);
    end

endmodule

// File: rtl/pipe_control.sv
// LEGv8 pipelined control: ID decode, ID/EX..MEM/WB control registers, NZVC flags,
// hazard stalls, EX forwarding selects and ID-stage branch resolution.
module pipe_control
    import ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter bit FLAG_FWD_EN = 1'b1,
    parameter bit DATA_FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_id,
    input  logic              instr_valid,
    input  logic [3:0]        ex_flags_in,
    input  logic              cbz_zero,
    output logic              stall,
    output logic              flush,
    output logic              br_taken,
    output logic              uncond_br,
    output logic [3:0]        flags,
    output logic [2:0]        ex_alu_op,
    output logic [1:0]        ex_alu_src,
    output logic              ex_set_flag,
    output logic              ex_is_movz,
    output logic              ex_is_mov,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_ze,
    output logic [3:0]        mem_xfer_size,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_rd
);

    localparam logic [REG_AW-1:0] XZR = '1;

    ctrl_t             dec_ctrl, id_ctrl, ex_ctrl;
    id_info_t          dec_info, id_info;
    logic [REG_AW-1:0] id_rn, id_rb, id_rd, ex_rd, mem_rd;
    logic              mem_reg_write, mem_mem_to_reg;
    logic              ex_wr, mem_wr;
    logic              a_ex, b_ex, a_mem, b_mem;
    logic              load_use, cbz_haz, flag_haz, raw_haz, lt;
    logic [3:0]        br_flags;
    logic [1:0]        fwd_a_nxt, fwd_b_nxt;

    ctrl_decode #(.REG_AW(REG_AW)) u_decode (
        .instr (instr_id),
        .ctrl  (dec_ctrl),
        .info  (dec_info),
        .rn    (id_rn),
        .rb    (id_rb),
        .rd    (id_rd)
    );

    always_comb begin
        id_ctrl = instr_valid ? dec_ctrl : CTRL_BUBBLE;
        id_info = instr_valid ? dec_info : ID_NONE;

        ex_wr  = ex_ctrl.reg_write && (ex_rd != XZR);
        mem_wr = mem_reg_write && (mem_rd != XZR);
        a_ex   = id_info.use_rn && (id_rn != XZR) && (id_rn == ex_rd);
        b_ex   = id_info.use_rb && (id_rb != XZR) && (id_rb == ex_rd);
        a_mem  = id_info.use_rn && (id_rn != XZR) && (id_rn == mem_rd);
        b_mem  = id_info.use_rb && (id_rb != XZR) && (id_rb == mem_rd);

        load_use = ex_ctrl.mem_read && (ex_rd != XZR) && (a_ex || b_ex);
        cbz_haz  = id_info.cbz && ((ex_wr && b_ex) || (mem_wr && b_mem));
        flag_haz = !FLAG_FWD_EN && id_info.blt && ex_ctrl.set_flag;
        raw_haz  = !DATA_FWD_EN && ((ex_wr && (a_ex || b_ex)) || (mem_wr && (a_mem || b_mem)));
        stall    = load_use || cbz_haz || flag_haz || raw_haz;

        // With flag forwarding off, a flag-setting EX stalls B.LT, so this mux then only ever sees the register.
        br_flags  = ex_ctrl.set_flag ? ex_flags_in : flags;
        lt        = br_flags[3] ^ br_flags[1];
        uncond_br = !stall && id_info.uncond;
        br_taken  = !stall && (id_info.uncond || (id_info.cbz && cbz_zero) || (id_info.blt && lt));
        flush     = br_taken;

        fwd_a_nxt = 2'b00;
        fwd_b_nxt = 2'b00;
        if (DATA_FWD_EN && !stall) begin
            if (ex_wr && a_ex)        fwd_a_nxt = 2'b01;
            else if (mem_wr && a_mem) fwd_a_nxt = 2'b10;
            if (ex_wr && b_ex)        fwd_b_nxt = 2'b01;
            else if (mem_wr && b_mem) fwd_b_nxt = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl        <= CTRL_BUBBLE;
            ex_rd          <= '0;
            fwd_a          <= '0;
            fwd_b          <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_ze         <= 1'b0;
            mem_xfer_size  <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_rd         <= '0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_rd          <= '0;
            flags          <= '0;
        end else begin
            ex_ctrl        <= stall ? CTRL_BUBBLE : id_ctrl;
            ex_rd          <= stall ? '0 : id_rd;
            fwd_a          <= fwd_a_nxt;
            fwd_b          <= fwd_b_nxt;
            mem_write      <= ex_ctrl.mem_write;
            mem_read       <= ex_ctrl.mem_read;
            mem_ze         <= ex_ctrl.mem_ze;
            mem_xfer_size  <= ex_ctrl.xfer_size;
            mem_reg_write  <= ex_ctrl.reg_write;
            mem_mem_to_reg <= ex_ctrl.mem_to_reg;
            mem_rd         <= ex_rd;
            wb_reg_write   <= mem_reg_write;
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_rd          <= mem_rd;
            if (ex_ctrl.set_flag) flags <= ex_flags_in;
        end
    end

    assign ex_alu_op   = ex_ctrl.alu_op;
    assign ex_alu_src  = ex_ctrl.alu_src;
    assign ex_set_flag = ex_ctrl.set_flag;
    assign ex_is_movz  = ex_ctrl.is_movz;
    assign ex_is_mov   = ex_ctrl.is_mov;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: default instance plus one with flag forwarding disabled.
module tb_pipe_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_id;
    logic        instr_valid;
    logic [3:0]  ex_flags_in;
    logic        cbz_zero;

    logic       stall, flush, br_taken, uncond_br, ex_set_flag, ex_is_movz, ex_is_mov;
    logic [3:0] flags, mem_xfer_size;
    logic [2:0] ex_alu_op;
    logic [1:0] ex_alu_src, fwd_a, fwd_b;
    logic       mem_write, mem_read, mem_ze, wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_rd;

    logic       n_stall, n_flush, n_br_taken, n_uncond_br, n_ex_set_flag, n_ex_is_movz, n_ex_is_mov;
    logic [3:0] n_flags, n_mem_xfer_size;
    logic [2:0] n_ex_alu_op;
    logic [1:0] n_ex_alu_src, n_fwd_a, n_fwd_b;
    logic       n_mem_write, n_mem_read, n_mem_ze, n_wb_reg_write, n_wb_mem_to_reg;
    logic [4:0] n_wb_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_control #(.REG_AW(5), .FLAG_FWD_EN(1'b1), .DATA_FWD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .instr_valid(instr_valid),
        .ex_flags_in(ex_flags_in), .cbz_zero(cbz_zero),
        .stall(stall), .flush(flush), .br_taken(br_taken), .uncond_br(uncond_br),
        .flags(flags), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_set_flag(ex_set_flag), .ex_is_movz(ex_is_movz), .ex_is_mov(ex_is_mov),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_write(mem_write), .mem_read(mem_read),
        .mem_ze(mem_ze), .mem_xfer_size(mem_xfer_size), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
    );

    pipe_control #(.REG_AW(5), .FLAG_FWD_EN(1'b0), .DATA_FWD_EN(1'b1)) dut_nf (
        .clk(clk), .reset(reset), .instr_id(instr_id), .instr_valid(instr_valid),
        .ex_flags_in(ex_flags_in), .cbz_zero(cbz_zero),
        .stall(n_stall), .flush(n_flush), .br_taken(n_br_taken), .uncond_br(n_uncond_br),
        .flags(n_flags), .ex_alu_op(n_ex_alu_op), .ex_alu_src(n_ex_alu_src),
        .ex_set_flag(n_ex_set_flag), .ex_is_movz(n_ex_is_movz), .ex_is_mov(n_ex_is_mov),
        .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .mem_write(n_mem_write), .mem_read(n_mem_read),
        .mem_ze(n_mem_ze), .mem_xfer_size(n_mem_xfer_size), .wb_reg_write(n_wb_reg_write),
        .wb_mem_to_reg(n_wb_mem_to_reg), .wb_rd(n_wb_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic vld);
        instr_id    = ins;
        instr_valid = vld;
        #1;
    endtask

    function automatic logic [31:0] ldur(input logic [4:0] rt, input logic [4:0] rn);
        return {11'b11111000010, 9'd0, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] adds(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'b10101011000, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] subs(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'b11101011000, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
        return {10'b1001000100, imm, rn, rd};
    endfunction
    function automatic logic [31:0] blt();
        return {8'b01010100, 19'd4, 5'b01011};
    endfunction
    function automatic logic [31:0] cbz(input logic [4:0] rt);
        return {8'b10110100, 19'd8, rt};
    endfunction
    function automatic logic [31:0] b_uncond();
        return {6'b000101, 26'd16};
    endfunction

    initial begin
        reset = 1'b1; instr_id = '0; instr_valid = 1'b0; ex_flags_in = '0; cbz_zero = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_flags", flags, 0);
        check("rst_memrd", mem_read, 0);
        check("rst_wbwr", wb_reg_write, 0);
        check("rst_brtk", br_taken, 0);

        // Reset mid-stream with LDUR in MEM and nonzero flags
        ex_flags_in = 4'b1000;
        drive(subs(5'd9, 5'd1, 5'd2), 1'b1); step();
        drive(ldur(5'd1, 5'd2), 1'b1); step();
        drive('0, 1'b0); step();
        check("mid_memrd_pre", mem_read, 1);
        check("mid_flags_pre", flags, 4'b1000);
        reset = 1'b1; step(); reset = 1'b0; #1;
        check("mid_memrd", mem_read, 0);
        check("mid_wbwr", wb_reg_write, 0);
        check("mid_flags", flags, 0);
        check("mid_setflag", ex_set_flag, 0);

        // Load-use: LDUR X1 then ADDS X3,X1,X4
        ex_flags_in = 4'b0000;
        drive(ldur(5'd1, 5'd2), 1'b1);
        check("lu_nostall0", stall, 0);
        step();
        drive(adds(5'd3, 5'd1, 5'd4), 1'b1);
        check("lu_stall", stall, 1);
        step();
        check("lu_bubble_sf", ex_set_flag, 0);
        check("lu_bubble_op", ex_alu_op, 3'b000);
        check("lu_memrd", mem_read, 1);
        check("lu_stall_once", stall, 0);
        step();
        check("lu_ex_sf", ex_set_flag, 1);
        check("lu_ex_op", ex_alu_op, 3'b010);
        check("lu_fwd_a", fwd_a, 2'b10);
        check("lu_fwd_b", fwd_b, 2'b00);
        check("lu_wb_wr", wb_reg_write, 1);
        check("lu_wb_m2r", wb_mem_to_reg, 1);
        check("lu_wb_rd", wb_rd, 5'd1);
        drive('0, 1'b0);

        // ADDI X5 then SUBS X6,X5,X5: EX forward on both operands
        drive(addi(5'd5, 5'd5, 12'd1), 1'b1);
        check("fw_nostall0", stall, 0);
        step();
        drive(subs(5'd6, 5'd5, 5'd5), 1'b1);
        check("fw_nostall1", stall, 0);
        step();
        check("fw_a", fwd_a, 2'b01);
        check("fw_b", fwd_b, 2'b01);
        check("fw_op", ex_alu_op, 3'b011);
        check("fw_src", ex_alu_src, 2'b00);

        // B.LT with SUBS in EX producing N=1,V=0
        ex_flags_in = 4'b1000;
        drive(blt(), 1'b1);
        check("blt_taken", br_taken, 1);
        check("blt_flush", flush, 1);
        check("blt_uncond", uncond_br, 0);
        check("blt_nf_stall", n_stall, 1);
        check("blt_nf_taken", n_br_taken, 0);
        step();
        ex_flags_in = 4'b0000;
        #1;
        check("blt_flags", flags, 4'b1000);
        check("blt_nf_stall2", n_stall, 0);
        check("blt_nf_taken2", n_br_taken, 1);
        drive('0, 1'b0); step();

        // LDUR X7 then CBZ X7: two stall cycles, then taken
        drive(ldur(5'd7, 5'd2), 1'b1); step();
        cbz_zero = 1'b1;
        drive(cbz(5'd7), 1'b1);
        check("cbz_stall1", stall, 1);
        check("cbz_br1", br_taken, 0);
        check("cbz_flush1", flush, 0);
        step();
        check("cbz_stall2", stall, 1);
        check("cbz_br2", br_taken, 0);
        step();
        check("cbz_stall3", stall, 0);
        check("cbz_taken", br_taken, 1);
        check("cbz_uncond", uncond_br, 0);
        check("cbz_flush", flush, 1);
        drive('0, 1'b0); cbz_zero = 1'b0; step();

        // Unconditional B, B.LT from register, B.LT not taken (N=V)
        drive(b_uncond(), 1'b1);
        check("b_taken", br_taken, 1);
        check("b_uncond", uncond_br, 1);
        step();
        drive(blt(), 1'b1);
        check("blt_reg_taken", br_taken, 1);
        step();
        drive(subs(5'd9, 5'd1, 5'd2), 1'b1); step();
        ex_flags_in = 4'b1010;
        drive(blt(), 1'b1);
        check("blt_nt", br_taken, 0);
        check("blt_nt_flush", flush, 0);
        check("blt_nt_nf_stall", n_stall, 1);
        drive('0, 1'b0); ex_flags_in = 4'b0000; step();

        // Unknown opcode, XZR destinations, invalid instruction
        drive(32'h0000_0000, 1'b1);
        check("unk_stall", stall, 0);
        check("unk_br", br_taken, 0);
        check("unk_uncond", uncond_br, 0);
        step();
        check("unk_sf", ex_set_flag, 0);
        check("unk_mov", ex_is_mov, 0);
        drive(addi(5'd31, 5'd1, 12'd1), 1'b1); step();
        drive(adds(5'd2, 5'd31, 5'd31), 1'b1);
        check("xzr_nostall", stall, 0);
        step();
        check("xzr_fwd_a", fwd_a, 2'b00);
        check("xzr_fwd_b", fwd_b, 2'b00);
        drive(ldur(5'd31, 5'd1), 1'b1); step();
        drive(adds(5'd2, 5'd31, 5'd3), 1'b1);
        check("xzr_ld_nostall", stall, 0);
        step();
        drive(ldur(5'd1, 5'd2), 1'b0); step();
        drive(adds(5'd3, 5'd1, 5'd4), 1'b1);
        check("inv_nostall", stall, 0);
        step();
        check("inv_fwd_a", fwd_a, 2'b00);
        drive('0, 1'b0); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
